// File: rtl/game_flow_controller.sv
// game_flow_controller: idle/countdown/play/hit/game-over sequencer and frame mux for the LED dodge game.
// Optional map speed-up ramp enabled by defining GAME_FLOW_SPEEDUP_EN.
module game_flow_controller #(
  parameter int COUNT_CYCLES  = 50_000_000,
  parameter int HIT_CYCLES    = 25_000_000,
  parameter int BLINK_CYCLES  = 12_500_000,
  parameter int LIVES         = 3,
  parameter int SPEEDUP_TICKS = 32
) (
  input  logic        system_clk,
  input  logic        rst,
  input  logic        left,
  input  logic        right,
  input  logic        map_tick,
  input  logic [63:0] map_fb,
  input  logic [63:0] live_fb,
  input  logic [2:0]  player_col,
  output logic        game_rst,
  output logic        run_en,
  output logic [63:0] disp_fb,
  output logic [2:0]  lives_left,
  output logic [1:0]  state,
  output logic [1:0]  speed_level
);
  localparam int CW = $clog2(COUNT_CYCLES > 1 ? COUNT_CYCLES : 2);
  localparam int HW = $clog2(HIT_CYCLES > 1 ? HIT_CYCLES : 2);
  localparam int BW = $clog2(BLINK_CYCLES > 1 ? BLINK_CYCLES : 2);
  localparam logic [63:0] IDLE_FB = 64'h0000_0018_1800_0000;
  localparam logic [2:0] S_IDLE = 3'd0, S_COUNT = 3'd1, S_PLAY = 3'd2, S_OVER = 3'd3, S_HIT = 3'd4;
  logic [2:0] fsm, fsm_n, lives_n;
  logic [1:0] step, step_n;
  logic [CW-1:0] ccnt, ccnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic blink, blink_n, press, hit, c_done, h_done, b_done, entry, stay;
  logic [63:0] disp_n;
  assign press  = left | right;
  assign hit    = map_tick & map_fb[{3'd7, player_col}];
  assign c_done = ccnt == CW'(COUNT_CYCLES - 1);
  assign h_done = hcnt == HW'(HIT_CYCLES - 1);
  assign b_done = bcnt == BW'(BLINK_CYCLES - 1);
  always_comb begin
    fsm_n   = fsm;
    step_n  = step;
    lives_n = lives_left;
    case (fsm)
      S_IDLE:  if (press) begin
        fsm_n   = S_COUNT;
        step_n  = 2'd3;
        lives_n = 3'(LIVES);
      end
      S_COUNT: if (c_done) begin
        fsm_n  = step == 2'd1 ? S_PLAY : S_COUNT;
        step_n = step == 2'd1 ? step : step - 2'd1;
      end
      S_PLAY:  if (hit) begin
        fsm_n   = lives_left > 3'd1 ? S_HIT : S_OVER;
        lives_n = lives_left > 3'd1 ? lives_left - 3'd1 : 3'd0;
      end
      S_HIT:   fsm_n = h_done ? S_PLAY : S_HIT;
      S_OVER:  fsm_n = press ? S_IDLE : S_OVER;
      default: fsm_n = S_IDLE;
    endcase
    entry   = fsm_n != fsm;
    stay    = (fsm_n == S_HIT || fsm_n == S_OVER) && !entry;
    ccnt_n  = (fsm_n != S_COUNT || entry || c_done) ? '0 : ccnt + 1'b1;
    hcnt_n  = (fsm_n != S_HIT || entry) ? '0 : h_done ? hcnt : hcnt + 1'b1;
    bcnt_n  = (stay && !b_done) ? bcnt + 1'b1 : '0;
    blink_n = stay ? blink ^ b_done : 1'b0;
    disp_n  = fsm_n == S_IDLE  ? IDLE_FB :
              fsm_n == S_COUNT ? (64'd1 << {step_n, 3'd0}) - 64'd1 :
              fsm_n == S_PLAY  ? live_fb :
              blink_n ? 64'd0 : live_fb;
  end
  always_ff @(posedge system_clk) begin
    if (rst) begin
      fsm        <= S_IDLE;
      step       <= 2'd0;
      ccnt       <= '0;
      hcnt       <= '0;
      bcnt       <= '0;
      blink      <= 1'b0;
      lives_left <= 3'(LIVES);
      game_rst   <= 1'b1;
      run_en     <= 1'b0;
      disp_fb    <= IDLE_FB;
      state      <= 2'd0;
    end else begin
      fsm        <= fsm_n;
      step       <= step_n;
      ccnt       <= ccnt_n;
      hcnt       <= hcnt_n;
      bcnt       <= bcnt_n;
      blink      <= blink_n;
      lives_left <= lives_n;
      game_rst   <= fsm_n == S_IDLE || fsm_n == S_COUNT;
      run_en     <= fsm_n == S_PLAY;
      disp_fb    <= disp_n;
      state      <= fsm_n == S_HIT ? 2'd2 : fsm_n[1:0];
    end
  end
`ifdef GAME_FLOW_SPEEDUP_EN
  logic [15:0] tcnt;
  always_ff @(posedge system_clk) begin
    if (rst || (fsm != S_COUNT && fsm_n == S_COUNT)) begin
      tcnt        <= 16'd0;
      speed_level <= 2'd0;
    end else if (fsm == S_PLAY && map_tick) begin
      tcnt        <= tcnt == 16'(SPEEDUP_TICKS - 1) ? 16'd0 : tcnt + 16'd1;
      speed_level <= (tcnt == 16'(SPEEDUP_TICKS - 1) && speed_level != 2'd3) ? speed_level + 2'd1 : speed_level;
    end
  end
`else
  assign speed_level = 2'd0;
`endif
endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: directed scenarios plus randomized run against an elapsed-time reference model.
module tb_game_flow_controller;
  localparam int CC = 4, HC = 6, BC = 2, LV = 3, ST = 2;
  localparam logic [63:0] IDLE_FB = 64'h0000_0018_1800_0000;
`ifdef GAME_FLOW_SPEEDUP_EN
  localparam bit SPD_EN = 1'b1;
`else
  localparam bit SPD_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_COUNT = 1, M_PLAY = 2, M_OVER = 3, M_HIT = 4;
  logic system_clk = 1'b0, rst = 1'b1, left = 1'b0, right = 1'b0, map_tick = 1'b0;
  logic [63:0] map_fb = '0, live_fb = '0;
  logic [2:0] player_col = '0;
  logic game_rst, run_en;
  logic [63:0] disp_fb;
  logic [2:0] lives_left;
  logic [1:0] state, speed_level;
  int n_cmp = 0, n_bad = 0;
  int mode = M_IDLE, t = 0, lives = LV, spd = 0, ticks = 0;
  logic [1:0] e_state;
  logic e_grst, e_run;
  logic [63:0] e_disp;
  logic [2:0] e_lives;
  logic [1:0] e_speed;

  game_flow_controller #(.COUNT_CYCLES(CC), .HIT_CYCLES(HC), .BLINK_CYCLES(BC), .LIVES(LV), .SPEEDUP_TICKS(ST)) dut (
    .system_clk(system_clk), .rst(rst), .left(left), .right(right), .map_tick(map_tick),
    .map_fb(map_fb), .live_fb(live_fb), .player_col(player_col), .game_rst(game_rst),
    .run_en(run_en), .disp_fb(disp_fb), .lives_left(lives_left), .state(state), .speed_level(speed_level));

  always #5 system_clk = ~system_clk;

  // Model tracks time since phase entry rather than explicit counters.
  always @(posedge system_clk) begin
    int nm;
    nm = mode;
    if (rst) begin
      nm = M_IDLE; lives = LV; spd = 0; ticks = 0;
    end else begin
      case (mode)
        M_IDLE:  if (left || right) begin nm = M_COUNT; lives = LV; spd = 0; ticks = 0; end
        M_COUNT: if (t + 1 == 3 * CC) nm = M_PLAY;
        M_PLAY:  if (map_tick) begin
          ticks++;
          if (SPD_EN && ticks % ST == 0 && spd < 3) spd++;
          if (map_fb[56 + int'(player_col)]) begin
            lives--;
            nm = lives == 0 ? M_OVER : M_HIT;
          end
        end
        M_HIT:   if (t + 1 == HC) nm = M_PLAY;
        M_OVER:  if (left || right) nm = M_IDLE;
        default: nm = M_IDLE;
      endcase
    end
    t = (rst || nm != mode) ? 0 : t + 1;
    mode = nm;
    e_state = mode == M_HIT ? 2'd2 : 2'(mode);
    e_grst  = mode == M_IDLE || mode == M_COUNT;
    e_run   = mode == M_PLAY;
    e_disp  = mode == M_IDLE ? IDLE_FB :
              mode == M_COUNT ? (64'd1 << (8 * (3 - t / CC))) - 64'd1 :
              mode == M_PLAY ? live_fb :
              ((t / BC) % 2 == 1) ? 64'd0 : live_fb;
    e_lives = 3'(lives);
    e_speed = 2'(spd);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge system_clk);
  endtask

  task automatic start_game();
    right = 1'b1; cyc(1); right = 1'b0; cyc(3 * CC);
  endtask

  task automatic do_hit(input logic [2:0] col);
    player_col = col; map_fb = 64'd1 << (56 + int'(col)); map_tick = 1'b1;
    cyc(1);
    map_tick = 1'b0; map_fb = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; live_fb = {$urandom, $urandom}; cyc(2); rst = 1'b0;
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (game_rst !== 1'b1) begin n_bad++; $display("FAIL reset_game_rst got %b want 1", game_rst); end
    n_cmp++; if (run_en !== 1'b0) begin n_bad++; $display("FAIL reset_run_en got %b want 0", run_en); end
    n_cmp++; if (disp_fb !== IDLE_FB) begin n_bad++; $display("FAIL reset_disp got %h want %h", disp_fb, IDLE_FB); end
    n_cmp++; if (lives_left !== 3'(LV)) begin n_bad++; $display("FAIL reset_lives got %0d want %0d", lives_left, LV); end
    n_cmp++; if (speed_level !== 2'd0) begin n_bad++; $display("FAIL reset_speed got %0d want 0", speed_level); end
    cyc(1);
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL idle_hold got %0d want 0", state); end
  endtask

  task automatic test_countdown();
    logic [63:0] m;
    right = 1'b1; cyc(1); right = 1'b0;
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL count_entry_state got %0d want 1", state); end
    n_cmp++; if (disp_fb !== 64'h0000_0000_00FF_FFFF) begin n_bad++; $display("FAIL count_entry_disp got %h want 0000000000ffffff", disp_fb); end
    for (int k = 1; k < 3 * CC; k++) begin
      cyc(1);
      m = (64'd1 << (8 * (3 - k / CC))) - 64'd1;
      n_cmp++; if (disp_fb !== m || state !== 2'd1 || game_rst !== 1'b1) begin n_bad++; $display("FAIL count_step%0d got disp=%h st=%0d grst=%b want disp=%h st=1 grst=1", k, disp_fb, state, game_rst, m); end
    end
    cyc(1);
    n_cmp++; if (state !== 2'd2 || game_rst !== 1'b0 || run_en !== 1'b1) begin n_bad++; $display("FAIL play_entry got st=%0d grst=%b run=%b want st=2 grst=0 run=1", state, game_rst, run_en); end
    live_fb = {$urandom, $urandom}; m = live_fb; cyc(1);
    n_cmp++; if (disp_fb !== m) begin n_bad++; $display("FAIL play_disp got %h want %h", disp_fb, m); end
  endtask

  task automatic test_hit();
    do_hit(3'd5);
    n_cmp++; if (lives_left !== 3'd2 || state !== 2'd2 || run_en !== 1'b0) begin n_bad++; $display("FAIL hit_entry got lives=%0d st=%0d run=%b want lives=2 st=2 run=0", lives_left, state, run_en); end
    for (int k = 1; k < HC; k++) begin
      cyc(1);
      n_cmp++; if (run_en !== 1'b0 || state !== 2'd2) begin n_bad++; $display("FAIL hit_hold%0d got run=%b st=%0d want run=0 st=2", k, run_en, state); end
    end
    cyc(1);
    n_cmp++; if (run_en !== 1'b1 || state !== 2'd2) begin n_bad++; $display("FAIL hit_return got run=%b st=%0d want run=1 st=2", run_en, state); end
  endtask

  task automatic test_fatal();
    logic [63:0] lv;
    do_hit(3'd1);
    cyc(1);
    do_hit(3'd1);
    n_cmp++; if (lives_left !== 3'd1) begin n_bad++; $display("FAIL hit_frozen_tick got lives=%0d want 1", lives_left); end
    cyc(HC - 2);
    n_cmp++; if (run_en !== 1'b1) begin n_bad++; $display("FAIL hit2_return got run=%b want 1", run_en); end
    lv = {$urandom, $urandom}; live_fb = lv; left = 1'b1;
    do_hit(3'd7);
    left = 1'b0;
    n_cmp++; if (lives_left !== 3'd0 || state !== 2'd3) begin n_bad++; $display("FAIL over_entry got lives=%0d st=%0d want lives=0 st=3", lives_left, state); end
    n_cmp++; if (disp_fb !== lv) begin n_bad++; $display("FAIL over_phase0 got %h want %h", disp_fb, lv); end
    for (int k = 1; k < 9; k++) begin
      lv = {$urandom, $urandom}; live_fb = lv; cyc(1);
      n_cmp++; if (disp_fb !== (((k / BC) % 2 == 1) ? 64'd0 : lv) || state !== 2'd3) begin n_bad++; $display("FAIL over_blink%0d got disp=%h st=%0d live=%h", k, disp_fb, state, lv); end
    end
    left = 1'b1; cyc(1); left = 1'b0;
    n_cmp++; if (state !== 2'd0 || game_rst !== 1'b1 || disp_fb !== IDLE_FB) begin n_bad++; $display("FAIL over_exit got st=%0d grst=%b disp=%h want st=0 grst=1 disp=%h", state, game_rst, disp_fb, IDLE_FB); end
  endtask

  task automatic test_miss_and_reset();
    start_game();
    player_col = 3'd2; map_fb = ~(64'd1 << 58); map_tick = 1'b1; right = 1'b1;
    cyc(1);
    map_tick = 1'b0; right = 1'b0; map_fb = '0;
    n_cmp++; if (lives_left !== 3'(LV) || state !== 2'd2 || run_en !== 1'b1) begin n_bad++; $display("FAIL miss got lives=%0d st=%0d run=%b want lives=%0d st=2 run=1", lives_left, state, run_en, LV); end
    rst = 1'b1; cyc(1); rst = 1'b0;
    right = 1'b1; cyc(1); right = 1'b0; cyc(3);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL recount got st=%0d want 1", state); end
    rst = 1'b1; cyc(1);
    n_cmp++; if (state !== 2'd0 || game_rst !== 1'b1 || run_en !== 1'b0 || disp_fb !== IDLE_FB || lives_left !== 3'(LV) || speed_level !== 2'd0) begin n_bad++; $display("FAIL mid_reset got st=%0d grst=%b run=%b disp=%h lives=%0d spd=%0d", state, game_rst, run_en, disp_fb, lives_left, speed_level); end
    rst = 1'b0;
  endtask

  task automatic test_speed();
    int e;
    start_game();
    player_col = 3'd0; map_fb = '0;
    for (int i = 1; i <= 8; i++) begin
      map_tick = 1'b1; cyc(1); map_tick = 1'b0; cyc(1);
      e = SPD_EN ? ((i / ST) > 3 ? 3 : i / ST) : 0;
      n_cmp++; if (speed_level !== 2'(e)) begin n_bad++; $display("FAIL speed_tick%0d got %0d want %0d", i, speed_level, e); end
    end
  endtask

  task automatic test_random();
    rst = 1'b1; cyc(1); rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst        = $urandom_range(0, 499) == 0;
      left       = $urandom_range(0, 7) == 0;
      right      = $urandom_range(0, 9) == 0;
      map_tick   = $urandom_range(0, 2) == 0;
      map_fb     = {$urandom, $urandom};
      live_fb    = {$urandom, $urandom};
      player_col = 3'($urandom_range(0, 7));
      cyc(1);
      n_cmp++; if (state !== e_state) begin n_bad++; $display("FAIL rnd_state@%0d got %0d want %0d", i, state, e_state); end
      n_cmp++; if (game_rst !== e_grst || run_en !== e_run) begin n_bad++; $display("FAIL rnd_ctrl@%0d got grst=%b run=%b want grst=%b run=%b", i, game_rst, run_en, e_grst, e_run); end
      n_cmp++; if (disp_fb !== e_disp) begin n_bad++; $display("FAIL rnd_disp@%0d got %h want %h", i, disp_fb, e_disp); end
      n_cmp++; if (lives_left !== e_lives) begin n_bad++; $display("FAIL rnd_lives@%0d got %0d want %0d", i, lives_left, e_lives); end
      n_cmp++; if (speed_level !== e_speed) begin n_bad++; $display("FAIL rnd_speed@%0d got %0d want %0d", i, speed_level, e_speed); end
    end
    rst = 1'b0; left = 1'b0; right = 1'b0; map_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_hit();
    test_fatal();
    test_miss_and_reset();
    test_speed();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
